// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: valid/ready fetch handshake,
// stall/halt control, jump redirection with misalignment trapping, trap entry/return.
//
//   state   | meaning
//   BOOT    | just out of reset, PC = RESET_ADDR, no fetch request
//   RUN     | issuing fetch requests, PC advances on handshake or redirect
//   HALT    | no fetch request, PC held; resume or trap leaves
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = 'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC   = 'h0000_0100,
  parameter int              INST_BYTES = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            fetch_ready_i,
  input  logic            stall_i,
  input  logic            halt_req_i,
  input  logic            resume_i,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            trap_en_i,
  input  logic [XLEN-1:0] trap_epc_i,
  input  logic            ret_en_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] epc_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o,
  output logic            halted_o
);

  localparam int ALIGN_W = $clog2(INST_BYTES);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
  logic            pc_valid_q, pc_valid_d;
  logic            halted_q, halted_d;
  logic            jump_misaligned;

  assign jump_misaligned = (jump_addr_i[ALIGN_W-1:0] != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= ST_BOOT;
      pc_q            <= RESET_ADDR;
      epc_q           <= '0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
      pc_valid_q      <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      epc_q           <= epc_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
      pc_valid_q      <= pc_valid_d;
      halted_q        <= halted_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    epc_d           = epc_q;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (trap_en_i) begin
          pc_d  = TRAP_VEC;
          epc_d = trap_epc_i;
        end else if (ret_en_i) begin
          pc_d = epc_q;
        end else if (jump_en_i) begin
          // A misaligned target traps instead of being fetched
          if (jump_misaligned) begin
            pc_d            = TRAP_VEC;
            epc_d           = jump_addr_i;
            misalign_d      = 1'b1;
            misalign_addr_d = jump_addr_i;
          end else begin
            pc_d = jump_addr_i;
          end
        end else if (halt_req_i) begin
          state_d = ST_HALT;
        end else if (!stall_i && fetch_ready_i) begin
          pc_d = pc_q + XLEN'(INST_BYTES);
        end
      end
      ST_HALT: begin
        if (trap_en_i) begin
          pc_d    = TRAP_VEC;
          epc_d   = trap_epc_i;
          state_d = ST_RUN;
        end else if (resume_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    pc_valid_d = (state_d == ST_RUN);
    halted_d   = (state_d == ST_HALT);
  end

  assign pc_o            = pc_q;
  assign pc_valid_o      = pc_valid_q;
  assign epc_o           = epc_q;
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;
  assign halted_o        = halted_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios against spec constants,
// then randomized traffic against a cycle-level behavioural model.
module tb_pc_gen;

  localparam int          XLEN = 32;
  localparam logic [31:0] TV   = 32'h0000_0100;
  localparam int          IB   = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fetch_ready_i = 1'b0, stall_i = 1'b0, halt_req_i = 1'b0, resume_i = 1'b0;
  logic        jump_en_i = 1'b0, trap_en_i = 1'b0, ret_en_i = 1'b0;
  logic [31:0] jump_addr_i = '0, trap_epc_i = '0;
  logic [31:0] pc_o, epc_o, misalign_addr_o;
  logic        pc_valid_o, misalign_o, halted_o;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  bit          m_boot, m_halted, m_valid, m_mis;
  logic [31:0] m_pc, m_epc, m_mis_addr;

  pc_gen #(.XLEN(XLEN), .RESET_ADDR(32'h0), .TRAP_VEC(TV), .INST_BYTES(IB)) dut (
    .clk(clk), .rstn(rstn),
    .fetch_ready_i(fetch_ready_i), .stall_i(stall_i), .halt_req_i(halt_req_i),
    .resume_i(resume_i), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .trap_en_i(trap_en_i), .trap_epc_i(trap_epc_i), .ret_en_i(ret_en_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .epc_o(epc_o),
    .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o), .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_boot = 1; m_halted = 0; m_valid = 0; m_mis = 0;
    m_pc = 32'h0; m_epc = 32'h0; m_mis_addr = 32'h0;
  endtask

  // Apply the next-PC rules to the inputs sampled at this edge.
  task automatic model_step();
    m_mis = 0;
    if (!rstn) begin
      model_reset();
    end else if (m_boot) begin
      m_boot = 0; m_valid = 1;
    end else if (m_halted) begin
      if (trap_en_i) begin
        m_pc = TV; m_epc = trap_epc_i; m_halted = 0; m_valid = 1;
      end else if (resume_i) begin
        m_halted = 0; m_valid = 1;
      end
    end else begin
      if (trap_en_i) begin
        m_pc = TV; m_epc = trap_epc_i;
      end else if (ret_en_i) begin
        m_pc = m_epc;
      end else if (jump_en_i) begin
        if (jump_addr_i % IB == 0) m_pc = jump_addr_i;
        else begin
          m_pc = TV; m_epc = jump_addr_i; m_mis = 1; m_mis_addr = jump_addr_i;
        end
      end else if (halt_req_i) begin
        m_halted = 1; m_valid = 0;
      end else if (!stall_i && fetch_ready_i) begin
        m_pc = m_pc + IB;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_ready_i = 0; stall_i = 0; halt_req_i = 0; resume_i = 0;
    jump_en_i = 0; trap_en_i = 0; ret_en_i = 0;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    n_checks++; if (pc_o !== 32'h0)       begin n_fail++; $display("FAIL reset_pc got %h exp 0", pc_o); end
    n_checks++; if (pc_valid_o !== 1'b0)  begin n_fail++; $display("FAIL reset_valid got %b exp 0", pc_valid_o); end
    n_checks++; if (epc_o !== 32'h0)      begin n_fail++; $display("FAIL reset_epc got %h exp 0", epc_o); end
    n_checks++; if (misalign_o !== 1'b0 || misalign_addr_o !== 32'h0)
      begin n_fail++; $display("FAIL reset_mis got %b/%h exp 0/0", misalign_o, misalign_addr_o); end
    n_checks++; if (halted_o !== 1'b0)    begin n_fail++; $display("FAIL reset_halted got %b exp 0", halted_o); end
  endtask

  task automatic test_seq_fetch();
    @(posedge clk); #1;
    rstn = 1; fetch_ready_i = 1;
    n_checks++; if (pc_valid_o !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %b exp 0", pc_valid_o); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (pc_valid_o !== 1'b1 || pc_o !== 32'(i * 4))
        begin n_fail++; $display("FAIL seq_fetch[%0d] got %b/%h exp 1/%h", i, pc_valid_o, pc_o, 32'(i * 4)); end
    end
  endtask

  task automatic test_backpressure();
    fetch_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (pc_o !== 32'h10) begin n_fail++; $display("FAIL bp_hold[%0d] got %h exp 10", i, pc_o); end
    end
    fetch_ready_i = 1; stall_i = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (pc_o !== 32'h10) begin n_fail++; $display("FAIL stall_hold[%0d] got %h exp 10", i, pc_o); end
    end
    stall_i = 0;
    tick();
    n_checks++; if (pc_o !== 32'h14) begin n_fail++; $display("FAIL bp_release got %h exp 14", pc_o); end
  endtask

  task automatic test_jumps();
    stall_i = 1; jump_en_i = 1; jump_addr_i = 32'h200;
    tick();
    n_checks++; if (pc_o !== 32'h200 || misalign_o !== 1'b0)
      begin n_fail++; $display("FAIL jump_stall got %h/%b exp 200/0", pc_o, misalign_o); end
    stall_i = 0; jump_addr_i = 32'h202;
    tick();
    n_checks++; if (pc_o !== TV || epc_o !== 32'h202)
      begin n_fail++; $display("FAIL misalign_pc got %h/%h exp %h/202", pc_o, epc_o, TV); end
    n_checks++; if (misalign_o !== 1'b1 || misalign_addr_o !== 32'h202)
      begin n_fail++; $display("FAIL misalign_flag got %b/%h exp 1/202", misalign_o, misalign_addr_o); end
    jump_en_i = 0; fetch_ready_i = 0;
    tick();
    n_checks++; if (misalign_o !== 1'b0 || misalign_addr_o !== 32'h202)
      begin n_fail++; $display("FAIL misalign_pulse got %b/%h exp 0/202", misalign_o, misalign_addr_o); end
  endtask

  task automatic test_trap_ret();
    trap_en_i = 1; trap_epc_i = 32'h40; jump_en_i = 1; jump_addr_i = 32'h80;
    tick();
    n_checks++; if (pc_o !== 32'h100 || epc_o !== 32'h40)
      begin n_fail++; $display("FAIL trap_vs_jump got %h/%h exp 100/40", pc_o, epc_o); end
    idle(); ret_en_i = 1;
    tick();
    n_checks++; if (pc_o !== 32'h40) begin n_fail++; $display("FAIL trap_ret got %h exp 40", pc_o); end
    ret_en_i = 1; trap_en_i = 1; trap_epc_i = 32'h88;
    tick();
    n_checks++; if (pc_o !== TV || epc_o !== 32'h88)
      begin n_fail++; $display("FAIL trap_vs_ret got %h/%h exp %h/88", pc_o, epc_o, TV); end
    idle();
  endtask

  task automatic test_wrap();
    jump_en_i = 1; jump_addr_i = 32'hFFFF_FFFC; fetch_ready_i = 1;
    tick();
    jump_en_i = 0;
    n_checks++; if (pc_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_jump got %h exp fffffffc", pc_o); end
    tick();
    n_checks++; if (pc_o !== 32'h0 || misalign_o !== 1'b0)
      begin n_fail++; $display("FAIL wrap_inc got %h/%b exp 0/0", pc_o, misalign_o); end
  endtask

  task automatic test_halt();
    logic [31:0] held;
    held = pc_o;
    fetch_ready_i = 1; halt_req_i = 1;
    tick();
    halt_req_i = 0;
    n_checks++; if (halted_o !== 1'b1 || pc_valid_o !== 1'b0 || pc_o !== held)
      begin n_fail++; $display("FAIL halt_enter got %b/%b/%h exp 1/0/%h", halted_o, pc_valid_o, pc_o, held); end
    jump_en_i = 1; jump_addr_i = 32'h300; ret_en_i = 1;
    tick(); tick();
    jump_en_i = 0; ret_en_i = 0;
    n_checks++; if (pc_o !== held || halted_o !== 1'b1)
      begin n_fail++; $display("FAIL halt_ignore got %h/%b exp %h/1", pc_o, halted_o, held); end
    resume_i = 1;
    tick();
    resume_i = 0;
    n_checks++; if (pc_valid_o !== 1'b1 || halted_o !== 1'b0 || pc_o !== held)
      begin n_fail++; $display("FAIL resume got %b/%b/%h exp 1/0/%h", pc_valid_o, halted_o, pc_o, held); end
    tick();
    n_checks++; if (pc_o !== held + 32'd4) begin n_fail++; $display("FAIL resume_inc got %h exp %h", pc_o, held + 32'd4); end
    halt_req_i = 1;
    tick();
    halt_req_i = 0; trap_en_i = 1; trap_epc_i = 32'h1234;
    tick();
    trap_en_i = 0;
    n_checks++; if (pc_o !== TV || epc_o !== 32'h1234 || pc_valid_o !== 1'b1)
      begin n_fail++; $display("FAIL halt_trap got %h/%h/%b exp %h/1234/1", pc_o, epc_o, pc_valid_o, TV); end
  endtask

  task automatic test_async_reset();
    halt_req_i = 1;
    tick();
    halt_req_i = 0;
    #2;
    rstn = 0;
    model_reset();
    #1;
    n_checks++; if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || epc_o !== 32'h0 || halted_o !== 1'b0 || misalign_addr_o !== 32'h0)
      begin n_fail++; $display("FAIL async_reset got %h/%b/%h/%b/%h exp 0/0/0/0/0", pc_o, pc_valid_o, epc_o, halted_o, misalign_addr_o); end
    @(posedge clk); #1;
    rstn = 1; fetch_ready_i = 1;
    n_checks++; if (pc_valid_o !== 1'b0) begin n_fail++; $display("FAIL reboot_valid got %b exp 0", pc_valid_o); end
    tick();
    n_checks++; if (pc_valid_o !== 1'b1 || pc_o !== 32'h0)
      begin n_fail++; $display("FAIL reboot_first got %b/%h exp 1/0", pc_valid_o, pc_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      fetch_ready_i = ($urandom_range(0, 3) != 0);
      stall_i       = ($urandom_range(0, 5) == 0);
      halt_req_i    = ($urandom_range(0, 15) == 0);
      resume_i      = ($urandom_range(0, 3) == 0);
      jump_en_i     = ($urandom_range(0, 7) == 0);
      jump_addr_i   = $urandom() & (($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      trap_en_i     = ($urandom_range(0, 19) == 0);
      trap_epc_i    = $urandom();
      ret_en_i      = ($urandom_range(0, 11) == 0);
      tick();
      n_checks++;
      if (pc_o !== m_pc || pc_valid_o !== m_valid || epc_o !== m_epc ||
          misalign_o !== m_mis || misalign_addr_o !== m_mis_addr || halted_o !== m_halted) begin
        n_fail++;
        $display("FAIL random[%0d] got pc=%h v=%b epc=%h mis=%b ma=%h h=%b exp pc=%h v=%b epc=%h mis=%b ma=%h h=%b",
                 i, pc_o, pc_valid_o, epc_o, misalign_o, misalign_addr_o, halted_o,
                 m_pc, m_valid, m_epc, m_mis, m_mis_addr, m_halted);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_backpressure();
    test_jumps();
    test_trap_ret();
    test_wrap();
    test_halt();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
